// File: rtl/iis_tx_fifo.sv
// I2S transmitter: FIFO-buffered L/R samples serialised MSB-first (Philips or left-justified).
// One pop per slot at BCLK fall; writes to a full FIFO are dropped with an overflow pulse.
module iis_tx_fifo #(
  parameter int DATA_W     = 16,
  parameter int SLOT_W     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int BCLK_DIV   = 4
) (
  input  logic                        pclk,
  input  logic                        presetn,
  input  logic [DATA_W-1:0]           datain,
  input  logic                        wrreq,
  input  logic                        mode,
  input  logic                        vol_clr,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        underrun,
  output logic                        i2s_bclk,
  output logic                        i2s_lrck,
  output logic                        i2s_sdata,
  output logic [DATA_W-2:0]           VolL,
  output logic [DATA_W-2:0]           VolR
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(BCLK_DIV);
  localparam int BW = $clog2(2 * SLOT_W);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [DW-1:0]     div_cnt, div_nxt;
  logic [BW-1:0]     bit_cnt, bit_nxt;
  logic [LW-1:0]     level_nxt;
  logic [DATA_W-1:0] head, neg;
  logic [DATA_W-2:0] mag;
  logic [SLOT_W-1:0] shreg, head_ext;
  logic              tick, frame_start, slot_end, enough;
  logic              pop_l, pop_r, pop, wr_ok;
  logic              dly, mode_r, frame_ok;

  always_comb begin
    tick        = (div_cnt == DW'(BCLK_DIV - 1));
    div_nxt     = tick ? '0 : div_cnt + DW'(1);
    frame_start = tick && (bit_cnt == BW'(2 * SLOT_W - 1));
    slot_end    = tick && (bit_cnt == BW'(SLOT_W - 1));
    bit_nxt     = frame_start ? '0 : bit_cnt + BW'(1);
    // A frame only starts when both words are present, so the right pop can never starve.
    enough      = (level >= LW'(2));
    pop_l       = frame_start && enough;
    pop_r       = slot_end && frame_ok;
    pop         = pop_l || pop_r;
    wr_ok       = wrreq && !full;
    level_nxt   = level + LW'(wr_ok) - LW'(pop);
    head        = mem[rd_ptr];
    head_ext    = '0;
    head_ext[SLOT_W-1 -: DATA_W] = head;
    neg         = -head;
    if (!head[DATA_W-1])     mag = head[DATA_W-2:0];
    else if (neg[DATA_W-1])  mag = '1;
    else                     mag = neg[DATA_W-2:0];
  end

  always_ff @(posedge pclk) begin
    if (wr_ok) mem[wr_ptr] <= datain;
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      i2s_bclk <= 1'b0;
      i2s_lrck <= 1'b0;
      shreg    <= '0;
      dly      <= 1'b0;
      mode_r   <= 1'b0;
      frame_ok <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
      underrun <= 1'b0;
      VolL     <= '0;
      VolR     <= '0;
    end else begin
      div_cnt  <= div_nxt;
      i2s_bclk <= (div_nxt >= DW'(BCLK_DIV / 2));
      if (tick) begin
        bit_cnt  <= bit_nxt;
        i2s_lrck <= (bit_nxt >= BW'(SLOT_W));
        dly      <= shreg[SLOT_W-1];
        if (frame_start) begin
          mode_r   <= mode;
          frame_ok <= enough;
          shreg    <= enough ? head_ext : '0;
        end else if (slot_end) begin
          shreg    <= frame_ok ? head_ext : '0;
        end else begin
          shreg    <= shreg << 1;
        end
      end
      underrun <= frame_start && !enough;
      overflow <= wrreq && full;
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      level    <= level_nxt;
      full     <= (level_nxt == LW'(FIFO_DEPTH));
      // A clear coinciding with a pop restarts the peak from the new sample.
      if (pop_l)        VolL <= (vol_clr || mag > VolL) ? mag : VolL;
      else if (vol_clr) VolL <= '0;
      if (pop_r)        VolR <= (vol_clr || mag > VolR) ? mag : VolR;
      else if (vol_clr) VolR <= '0;
    end
  end

  assign i2s_sdata = mode_r ? shreg[SLOT_W-1] : dly;

endmodule
